uart_tx_128: RTL and testbench

//  8N1 UART transmitter that serialises one 128-bit word as 16 bytes on one line.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 89 ++++++++
 rtl/uart_tx_128.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_128.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART constants, FSM encoding and baud-divider helper,
//             used by both the 128-bit transmitter and its receiver peer.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int FRAME_BYTES = 16;
    localparam int BYTE_BITS   = 8;

    // Transmit sequencing states; the byte serialiser is driven from these.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    // Clocks per bit-time for a given system clock and line rate.
    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_byte
//  Brief    : Single-byte 8N1 serialiser. Owns the baud and bit counters and
//             the registered line output; phase sequencing comes from the
//             frame-level state supplied by the parent.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_CNT_MAX = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,      // next cycle begins a start bit
    input  tx_state_e  state,      // current frame-level phase
    input  logic [7:0] data,       // byte being sent, stable for the whole byte
    output logic       tx,
    output logic       bit_end,    // last clock of the current bit-time
    output logic       last_bit,   // bit counter sits on the final data bit
    output logic       byte_done   // last clock of the stop bit
);

    localparam int c_BAUD_W = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_cnt;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_bit_end;

    assign w_bit_end = (state != ST_IDLE) && (r_baud_cnt == c_BAUD_LAST);
    assign bit_end   = w_bit_end;
    assign last_bit  = (r_bit_cnt == 3'd7);
    assign byte_done = (state == ST_STOP) && w_bit_end;
    assign tx        = r_tx;

    // Bit-time divider: free-runs while a frame is active, restarts on each byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
        end else if (start || (state == ST_IDLE) || w_bit_end) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
        end
    end

    // Data-bit index; wraps from 7 back to 0 as the last data bit ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (start) begin
            r_bit_cnt <= '0;
        end else if ((state == ST_DATA) && w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Next line level, chosen one cycle ahead so the output is a clean flop.
    always_comb begin
        w_tx_next = r_tx;
        if (start) begin
            w_tx_next = 1'b0;
        end else begin
            case (state)
                ST_START: if (w_bit_end) w_tx_next = data[0];
                ST_DATA:  if (w_bit_end) w_tx_next = (r_bit_cnt == 3'd7) ? 1'b1
                                                     : data[r_bit_cnt + 3'd1];
                ST_STOP:  if (w_bit_end) w_tx_next = 1'b1;
                default:  w_tx_next = 1'b1;
            endcase
        end
    end

    // Registered serial output; idles at mark and returns there on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_128.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_128
//  Brief    : 8N1 transmitter sending one 128-bit word as 16 bytes, most
//             significant byte first, with optional idle bit-times between
//             bytes. Requests arriving mid-frame are dropped and flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_128
    import uart_pkg::*;
#(
    parameter int UART_BPS = 'd9600,
    parameter int CLK_FREQ = 'd50_000_000,
    parameter int BYTE_GAP = 'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] pi_data,
    input  logic         pi_flag,
    output logic         tx,
    output logic         busy,
    output logic         po_done,
    output logic         po_drop
);

    localparam int         c_BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam logic [3:0] c_LAST_BYTE    = 4'(FRAME_BYTES - 1);
    localparam logic [3:0] c_GAP_LAST     = 4'((BYTE_GAP > 0) ? (BYTE_GAP - 1) : 0);
    localparam bit         c_HAS_GAP      = (BYTE_GAP != 0);

    if ((c_BAUD_CNT_MAX < 2) || (BYTE_GAP > 15) || (BYTE_GAP < 0)) begin : g_param_check
        $error("uart_tx_128: BAUD_CNT_MAX must be >= 2 and BYTE_GAP within 0..15");
    end

    tx_state_e    r_state;
    tx_state_e    w_next_state;
    logic [127:0] r_shreg;
    logic [3:0]   r_byte_cnt;
    logic [3:0]   r_gap_cnt;
    logic         r_busy;
    logic         r_done;
    logic         r_drop;
    logic         w_accept;
    logic         w_start;
    logic         w_bit_end;
    logic         w_last_bit;
    logic         w_byte_done;
    logic         w_frame_end;

    assign w_accept    = pi_flag && !r_busy;
    assign w_frame_end = w_byte_done && (r_byte_cnt == c_LAST_BYTE);

    assign busy    = r_busy;
    assign po_done = r_done;
    assign po_drop = r_drop;

    uart_tx_byte #(
        .BAUD_CNT_MAX (c_BAUD_CNT_MAX)
    ) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .state     (r_state),
        .data      (r_shreg[127:120]),
        .tx        (tx),
        .bit_end   (w_bit_end),
        .last_bit  (w_last_bit),
        .byte_done (w_byte_done)
    );

    // Frame sequencing; w_start marks every entry into a start bit.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_START;
                    w_start      = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && w_last_bit) w_next_state = ST_STOP;
            end
            ST_STOP: begin
                if (w_byte_done) begin
                    if (w_frame_end) begin
                        w_next_state = ST_IDLE;
                    end else if (c_HAS_GAP) begin
                        w_next_state = ST_GAP;
                    end else begin
                        w_next_state = ST_START;
                        w_start      = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_bit_end && (r_gap_cnt == c_GAP_LAST)) begin
                    w_next_state = ST_START;
                    w_start      = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word shift register: load on accept, advance one byte per stop-bit end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= pi_data;
        end else if (w_byte_done) begin
            r_shreg <= {r_shreg[119:0], 8'h00};
        end
    end

    // Bytes completed in this frame; rolls over to 0 with the final byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_byte_done) begin
            r_byte_cnt <= r_byte_cnt + 4'd1;
        end
    end

    // Idle bit-times elapsed inside an inter-byte gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (r_state != ST_GAP) begin
            r_gap_cnt <= '0;
        end else if (w_bit_end) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end
    end

    // Status flags: busy follows the next state, done/drop are single pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= w_frame_end;
            r_drop <= pi_flag && r_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_128.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_128
//  Brief    : Self-checking bench for uart_tx_128 with a line-level receiver
//             model and queued expectations (10 clk per bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_128;

    localparam int CLK_HZ    = 50_000_000;
    localparam int BPS       = 5_000_000;
    localparam int BIT_CLK   = CLK_HZ / BPS;
    localparam int FRAME_CLK = 160 * BIT_CLK;

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
    } byte_exp_t;

    logic         clk = 1'b0;
    int           cyc = 0;
    logic         rstn  [2];
    logic         pflag [2];
    logic [127:0] pdata [2];
    logic         txv   [2];
    logic         busyv [2];
    logic         donev [2];
    logic         dropv [2];

    byte_exp_t    line_q [2][$];
    logic [127:0] word_q [2][$];
    int           done_q [2][$];
    int           drop_q [2][$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_128 #(.UART_BPS(BPS), .CLK_FREQ(CLK_HZ), .BYTE_GAP(0)) dut (
        .clk(clk), .rst_n(rstn[0]), .pi_data(pdata[0]), .pi_flag(pflag[0]),
        .tx(txv[0]), .busy(busyv[0]), .po_done(donev[0]), .po_drop(dropv[0])
    );

    uart_tx_128 #(.UART_BPS(BPS), .CLK_FREQ(CLK_HZ), .BYTE_GAP(2)) dut_gap (
        .clk(clk), .rst_n(rstn[1]), .pi_data(pdata[1]), .pi_flag(pflag[1]),
        .tx(txv[1]), .busy(busyv[1]), .po_done(donev[1]), .po_drop(dropv[1])
    );

    function automatic int gap_of(input int g);
        return (g == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %s expected none (cycle %0d)", name, what, cyc);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Expected line and event timing derived from the frame rules.
    task automatic push_frame(input int g, input logic [127:0] d, input int n);
        int pitch;
        pitch = 10 * BIT_CLK + gap_of(g) * BIT_CLK;
        for (int k = 0; k < 16; k++) begin
            byte_exp_t e;
            e.data      = d[127 - 8*k -: 8];
            e.start_cyc = n + k * pitch;
            line_q[g].push_back(e);
        end
        word_q[g].push_back(d);
        done_q[g].push_back(n + FRAME_CLK + 15 * gap_of(g) * BIT_CLK);
    endtask

    // Called one delta after a rising edge; returns the accept cycle.
    task automatic send(input int g, input logic [127:0] d, output int n);
        pflag[g] = 1'b1;
        pdata[g] = d;
        tick(1);
        n = cyc;
        pflag[g] = 1'b0;
        push_frame(g, d, n);
        check($sformatf("accept_busy[%0d]", g), 128'(busyv[g]), 128'(1));
        check($sformatf("accept_tx[%0d]", g), 128'(txv[g]), 128'(0));
    endtask

    task automatic drop_pulse(input int g, input logic [127:0] d);
        pflag[g] = 1'b1;
        pdata[g] = d;
        tick(1);
        pflag[g] = 1'b0;
        drop_q[g].push_back(cyc);
    endtask

    task automatic wait_idle(input int g);
        int k;
        k = 0;
        while ((busyv[g] !== 1'b0) && (k < 5000)) begin
            tick(1);
            k++;
        end
        if (k >= 5000) fail_now($sformatf("idle_timeout[%0d]", g), "busy stuck");
    endtask

    // Line receiver model and event monitors, one per DUT instance.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        byte_exp_t    cur;
        bit           active = 1'b0;
        int           t0;
        logic         wav [100];
        int           nbytes = 0;
        logic [127:0] word;
        logic [7:0]   got;
        bit           stable;

        always @(negedge clk) begin
            if (rstn[g] !== 1'b1) begin
                active = 1'b0;
                nbytes = 0;
            end else if (!active) begin
                if (txv[g] === 1'b0) begin
                    if (line_q[g].size() == 0) begin
                        fail_now($sformatf("unexpected_start[%0d]", g), "start bit");
                        active = 1'b1;
                        cur.data = 8'h00;
                        cur.start_cyc = cyc;
                        t0 = cyc;
                        wav[0] = txv[g];
                    end else begin
                        cur = line_q[g].pop_front();
                        check($sformatf("start_cycle[%0d]", g), 128'(cyc), 128'(cur.start_cyc));
                        active = 1'b1;
                        t0 = cyc;
                        wav[0] = txv[g];
                    end
                end
            end else begin
                wav[cyc - t0] = txv[g];
                if (cyc - t0 == 10 * BIT_CLK - 1) begin
                    active = 1'b0;
                    for (int b = 0; b < 8; b++) got[b] = wav[BIT_CLK + BIT_CLK/2 + BIT_CLK*b];
                    stable = 1'b1;
                    for (int i = 0; i < 10 * BIT_CLK; i++)
                        if (wav[i] !== wav[(i / BIT_CLK) * BIT_CLK + BIT_CLK/2]) stable = 1'b0;
                    check($sformatf("byte_data[%0d]", g), 128'(got), 128'(cur.data));
                    check($sformatf("framing[%0d]", g),
                          128'({wav[BIT_CLK/2], wav[9*BIT_CLK + BIT_CLK/2]}), 128'(2'b01));
                    check($sformatf("bit_width[%0d]", g), 128'(stable), 128'(1));
                    word = {word[119:0], got};
                    nbytes++;
                    if (nbytes == 16) begin
                        nbytes = 0;
                        if (word_q[g].size() == 0) fail_now($sformatf("unexpected_word[%0d]", g), "word");
                        else check($sformatf("word[%0d]", g), word, word_q[g].pop_front());
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (rstn[g] === 1'b1) begin
                if (donev[g] === 1'b1) begin
                    if (done_q[g].size() == 0) fail_now($sformatf("unexpected_done[%0d]", g), "po_done");
                    else check($sformatf("done_cycle[%0d]", g), 128'(cyc), 128'(done_q[g].pop_front()));
                    check($sformatf("done_idle[%0d]", g), 128'({busyv[g], txv[g]}), 128'(2'b01));
                end
                if (dropv[g] === 1'b1) begin
                    if (drop_q[g].size() == 0) fail_now($sformatf("unexpected_drop[%0d]", g), "po_drop");
                    else check($sformatf("drop_cycle[%0d]", g), 128'(cyc), 128'(drop_q[g].pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk + 1, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        int o;
        logic [127:0] d;

        rstn[0] = 1'b0;  rstn[1] = 1'b0;
        pflag[0] = 1'b0; pflag[1] = 1'b0;
        pdata[0] = '0;   pdata[1] = '0;
        tick(5);

        // Reset values
        for (int g = 0; g < 2; g++)
            check($sformatf("reset_outputs[%0d]", g),
                  128'({txv[g], busyv[g], donev[g], dropv[g]}), 128'(4'b1000));
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle_after_reset", 128'({txv[0], busyv[0], donev[0]}), 128'(3'b100));
        end

        // Counting-byte frame
        send(0, 128'h000102030405060708090A0B0C0D0E0F, n);
        tick(FRAME_CLK + 5);

        // Loopback word
        send(0, 128'hDEADBEEF_0123456789ABCDEF_A5A55A5A, n);
        tick(FRAME_CLK + 5);

        // Request while busy is dropped without disturbing the frame
        send(0, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, n);
        tick(299);
        drop_pulse(0, 128'h11111111_22222222_33333333_44444444);
        tick(FRAME_CLK - 300);

        // Back-to-back: second request in the po_done cycle
        tick(5);
        send(0, 128'hC0FFEE00_12345678_9ABCDEF0_0BADF00D, n);
        tick(FRAME_CLK);
        send(0, 128'h5555AAAA_FFFF0000_00FF00FF_F0F00F0F, m);
        check("b2b_accept_busy", 128'(busyv[0]), 128'(1));
        tick(FRAME_CLK + 5);

        // All-zero word is still transmitted
        send(0, 128'h0, n);
        tick(FRAME_CLK + 5);

        // Randomised frames, drops and back-to-back spacing
        for (int r = 0; r < 6; r++) begin
            wait_idle(0);
            d = {$urandom, $urandom, $urandom, $urandom};
            send(0, d, n);
            if ($urandom_range(0, 1) == 1) begin
                o = int'($urandom_range(1, 1500));
                tick(o - 1);
                drop_pulse(0, {$urandom, $urandom, $urandom, $urandom});
                tick(FRAME_CLK - o);
            end else begin
                tick(FRAME_CLK);
            end
            if ($urandom_range(0, 2) != 0) tick(int'($urandom_range(1, 30)));
        end
        wait_idle(0);

        // Gapped instance: full frame
        send(1, 128'h0F0E0D0C_0B0A0908_07060504_03020100, n);
        tick(FRAME_CLK + 15 * 2 * BIT_CLK + 5);

        // Gapped instance: reset during byte 7's start bit
        send(1, {$urandom, $urandom, $urandom, $urandom}, n);
        tick(7 * 12 * BIT_CLK + 3);
        check("pre_reset_tx", 128'(txv[1]), 128'(0));
        rstn[1] = 1'b0;
        line_q[1].delete();
        word_q[1].delete();
        done_q[1].delete();
        #1;
        check("reset_async", 128'({txv[1], busyv[1]}), 128'(2'b10));
        tick(3);
        rstn[1] = 1'b1;
        tick(3);

        // Gapped instance: clean frame after the abort
        send(1, 128'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90, n);
        tick(FRAME_CLK + 15 * 2 * BIT_CLK + 5);

        tick(20);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("lines_pending[%0d]", g), 128'(line_q[g].size()), 128'(0));
            check($sformatf("words_pending[%0d]", g), 128'(word_q[g].size()), 128'(0));
            check($sformatf("done_pending[%0d]", g), 128'(done_q[g].size()), 128'(0));
            check($sformatf("drop_pending[%0d]", g), 128'(drop_q[g].size()), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
